// File: rtl/finn_stream_pkg.sv
// Shared helpers for FINN-style stream blocks: width-ratio arithmetic and
// the common two-state buffer encoding.
package finn_stream_pkg;

    typedef enum logic {
        SB_EMPTY = 1'b0,
        SB_FULL  = 1'b1
    } stream_buf_state_e;

    function automatic int dwc_ratio(input int inWidth, input int outWidth);
        return inWidth / outWidth;
    endfunction

    // Clamp to 1 so a counter register always has at least one bit.
    function automatic int dwc_idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/streaming_dwc_down.sv
// Down-converting stream width converter: each accepted IN_WIDTH word is
// emitted as RATIO OUT_WIDTH slices, least-significant slice first.
module streaming_dwc_down
    import finn_stream_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [IN_WIDTH-1:0]  in0_V_V_TDATA,
    input  logic                 in0_V_V_TVALID,
    output logic                 in0_V_V_TREADY,
    output logic [OUT_WIDTH-1:0] out_V_V_TDATA,
    output logic                 out_V_V_TVALID,
    input  logic                 out_V_V_TREADY,
    output logic                 busy
);

    localparam int RATIO = dwc_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int IDX_W = dwc_idx_width(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
            $error("streaming_dwc_down: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
        end
    endgenerate

    stream_buf_state_e     state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IN_WIDTH-1:0]   data_q, data_d;
    logic                  inXfer;
    logic                  outXfer;
    logic                  lastSlice;

    assign lastSlice      = (idx_q == LAST_IDX);
    assign in0_V_V_TREADY = (state_q == SB_EMPTY) || (lastSlice && out_V_V_TREADY);
    assign out_V_V_TVALID = (state_q == SB_FULL);
    assign out_V_V_TDATA  = data_q[int'(idx_q) * OUT_WIDTH +: OUT_WIDTH];
    assign busy           = (idx_q != '0);
    assign inXfer         = in0_V_V_TVALID && in0_V_V_TREADY;
    assign outXfer        = out_V_V_TVALID && out_V_V_TREADY;

    // A new word overrides the last-slice drain so back-to-back words stay FULL.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        if (outXfer) begin
            idx_d = lastSlice ? '0 : idx_q + IDX_W'(1);
            if (lastSlice) begin
                state_d = SB_EMPTY;
            end
        end
        if (inXfer) begin
            data_d  = in0_V_V_TDATA;
            idx_d   = '0;
            state_d = SB_FULL;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= SB_EMPTY;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

endmodule
